dmem: RTL

DMEM -- requirements
Module: dmem

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Data-memory request/response bus shared by the core (master) and dmem (slave).
// Handshake: a request is accepted on a posedge where req && ready; responses
// (rvalid, err) are one-cycle pulses with no back-pressure from the master.
interface dmem_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, funct3, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem.sv
// Byte-addressable RISC-V data memory: single-port synchronous RAM with byte
// enables, load sign/zero extension, misalignment faults, optional output stage.
module dmem #(
  parameter int AWIDTH = 10,
  parameter int OUTREG = 0
) (
  input  logic   clock,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t               state, state_nx;
  logic [3:0][7:0]      mem [DEPTH];
  logic [3:0][7:0]      raw_q;
  logic [AWIDTH-1:0]    idx;
  logic [1:0]           lane;
  logic [29-AWIDTH:0]   unused_addr_hi;
  logic                 accept, fault;
  logic [3:0]           be;
  logic [31:0]          wword;

  logic                 s1_ld, s1_st_err, s1_fault;
  logic [2:0]           s1_f3;
  logic [1:0]           s1_lane;
  logic                 s2_vld, s2_fault;
  logic [31:0]          ld_data, hold_q;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic                 rvalid_i, err_i;
  logic [31:0]          rdata_i;

  // Upper address bits alias onto the same words.
  assign idx            = bus.addr[AWIDTH+1:2];
  assign lane           = bus.addr[1:0];
  assign unused_addr_hi = bus.addr[31:AWIDTH+2];

  assign bus.ready = (state == IDLE) && !reset;
  assign accept    = bus.req && bus.ready;

  always_comb begin
    case (bus.funct3)
      3'b000:  fault = 1'b0;
      3'b001:  fault = bus.addr[0];
      3'b010:  fault = |bus.addr[1:0];
      3'b100:  fault = bus.we;
      3'b101:  fault = bus.we | bus.addr[0];
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wword = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM array is deliberately not reset so contents survive reset.
  always_ff @(posedge clock) begin
    if (accept && bus.we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i] <= wword[i*8 +: 8];
      end
    end
    raw_q <= mem[idx];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !bus.we && (OUTREG != 0)) state_nx = WAIT;
      WAIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    s1_fault <= fault;
    s1_f3    <= bus.funct3;
    s1_lane  <= lane;
    s2_fault <= s1_fault;
    if (reset) begin
      s1_ld     <= 1'b0;
      s1_st_err <= 1'b0;
      s2_vld    <= 1'b0;
      hold_q    <= '0;
    end else begin
      s1_ld     <= accept && !bus.we;
      s1_st_err <= accept && bus.we && fault;
      s2_vld    <= s1_ld;
      if (s1_ld) hold_q <= ld_data;
    end
  end

  always_comb begin
    byte_sel = raw_q[s1_lane];
    half_sel = s1_lane[1] ? raw_q[3:2] : raw_q[1:0];
    case (s1_f3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'd0, byte_sel};
      3'b101:  ld_data = {16'd0, half_sel};
      default: ld_data = raw_q;
    endcase
    if (s1_fault) ld_data = '0;
  end

  // Without the output stage the fresh load bypasses the hold register.
  always_comb begin
    if (OUTREG != 0) begin
      rvalid_i = s2_vld;
      err_i    = s1_st_err | (s2_vld & s2_fault);
      rdata_i  = hold_q;
    end else begin
      rvalid_i = s1_ld;
      err_i    = s1_st_err | (s1_ld & s1_fault);
      rdata_i  = s1_ld ? ld_data : hold_q;
    end
  end

  assign bus.rvalid = rvalid_i && !reset;
  assign bus.err    = err_i && !reset;
  assign bus.rdata  = reset ? 32'd0 : rdata_i;

endmodule
